// File: rtl/write_back_regfile.sv
// Nios2 write-back stage: registers the memory-stage bundle, commits it to a
// 32x32 register file one edge later, and counts retired instructions.
module write_back_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_1000,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic        clk_40,
    input  logic        rst_n_40,
    input  logic        valid_in_40,
    input  logic        stall_40,
    input  logic [5:0]  opcode_in_40,
    input  logic [5:0]  src_reg_in_40,
    input  logic [5:0]  dest_reg_in_40,
    input  logic [5:0]  targ_reg_in_40,
    input  logic [31:0] mem_out1_40,
    input  logic [31:0] mem_out2_40,
    output logic        wb_en_40,
    output logic [4:0]  wb_addr_40,
    output logic [31:0] wb_data_40,
    output logic [31:0] retire_cnt_40,
    output logic [31:0] r0,  output logic [31:0] r1,  output logic [31:0] r2,  output logic [31:0] r3,
    output logic [31:0] r4,  output logic [31:0] r5,  output logic [31:0] r6,  output logic [31:0] r7,
    output logic [31:0] r8,  output logic [31:0] r9,  output logic [31:0] r10, output logic [31:0] r11,
    output logic [31:0] r12, output logic [31:0] r13, output logic [31:0] r14, output logic [31:0] r15,
    output logic [31:0] r16, output logic [31:0] r17, output logic [31:0] r18, output logic [31:0] r19,
    output logic [31:0] r20, output logic [31:0] r21, output logic [31:0] r22, output logic [31:0] r23,
    output logic [31:0] r24, output logic [31:0] r25, output logic [31:0] r26, output logic [31:0] r27,
    output logic [31:0] r28, output logic [31:0] r29, output logic [31:0] r30, output logic [31:0] r31
);

    localparam int unsigned NREGS  = 32;
    localparam logic [5:0]  OP_NOPE = 6'b111111;
    localparam logic [4:0]  SP_IDX  = 5'd27;

    logic [31:0] regs [1:NREGS-1];
    logic [31:0] rd   [NREGS];
    logic        stage_valid;
    logic [5:0]  stage_opcode;
    logic [5:0]  stage_src;
    logic [31:0] stage_out2;
    logic [5:0]  dec_idx;
    logic        dec_has;
    logic        dec_wr;
    logic        unused_dbg;

    // Destination decode on the incoming opcode so the WB outputs can be registered
    always_comb begin
        dec_idx = 6'd0;
        dec_has = 1'b0;
        unique case (opcode_in_40)
            6'b110001, 6'b100111: begin
                dec_idx = dest_reg_in_40;
                dec_has = 1'b1;
            end
            6'b000100, 6'b011111, 6'b010111: begin
                dec_idx = targ_reg_in_40;
                dec_has = 1'b1;
            end
            6'b000000: begin
                dec_idx = 6'd31;
                dec_has = 1'b1;
            end
            default: begin
                dec_idx = 6'd0;
                dec_has = 1'b0;
            end
        endcase
        dec_wr = dec_has && !dec_idx[5] && (dec_idx[4:0] != 5'd0);
    end

    // WB stage register; a stall inserts a bubble
    always_ff @(posedge clk_40 or negedge rst_n_40) begin
        if (!rst_n_40) begin
            stage_valid  <= 1'b0;
            stage_opcode <= OP_NOPE;
            stage_src    <= 6'd0;
            stage_out2   <= 32'd0;
            wb_en_40     <= 1'b0;
            wb_addr_40   <= 5'd0;
            wb_data_40   <= 32'd0;
        end else begin
            stage_opcode <= opcode_in_40;
            stage_src    <= src_reg_in_40;
            stage_out2   <= mem_out2_40;
            if (stall_40) begin
                stage_valid <= 1'b0;
                wb_en_40    <= 1'b0;
                wb_addr_40  <= 5'd0;
                wb_data_40  <= 32'd0;
            end else begin
                stage_valid <= valid_in_40;
                wb_en_40    <= valid_in_40 && dec_wr;
                wb_addr_40  <= (valid_in_40 && dec_wr) ? dec_idx[4:0] : 5'd0;
                wb_data_40  <= (valid_in_40 && dec_wr) ? mem_out1_40 : 32'd0;
            end
        end
    end

    // Commit and retire
    always_ff @(posedge clk_40 or negedge rst_n_40) begin
        if (!rst_n_40) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= (5'(i) == SP_IDX) ? SP_INIT : 32'd0;
            end
            retire_cnt_40 <= 32'd0;
        end else begin
            if (wb_en_40) begin
                regs[wb_addr_40] <= wb_data_40;
            end
            if (stage_valid && (stage_opcode != OP_NOPE)) begin
                retire_cnt_40 <= retire_cnt_40 + 32'd1;
            end
        end
    end

    // Read ports with optional write-before-read bypass
    assign rd[0] = 32'd0;
    for (genvar g = 1; g < NREGS; g++) begin : g_rd
        assign rd[g] = (BYPASS && wb_en_40 && (wb_addr_40 == 5'(g))) ? wb_data_40 : regs[g];
    end

    assign unused_dbg = ^{stage_src, stage_out2};

    assign r0  = rd[0];  assign r1  = rd[1];  assign r2  = rd[2];  assign r3  = rd[3];
    assign r4  = rd[4];  assign r5  = rd[5];  assign r6  = rd[6];  assign r7  = rd[7];
    assign r8  = rd[8];  assign r9  = rd[9];  assign r10 = rd[10]; assign r11 = rd[11];
    assign r12 = rd[12]; assign r13 = rd[13]; assign r14 = rd[14]; assign r15 = rd[15];
    assign r16 = rd[16]; assign r17 = rd[17]; assign r18 = rd[18]; assign r19 = rd[19];
    assign r20 = rd[20]; assign r21 = rd[21]; assign r22 = rd[22]; assign r23 = rd[23];
    assign r24 = rd[24]; assign r25 = rd[25]; assign r26 = rd[26]; assign r27 = rd[27];
    assign r28 = rd[28]; assign r29 = rd[29]; assign r30 = rd[30]; assign r31 = rd[31];

endmodule

// File: tb/tb_write_back_regfile.sv
// Directed bench for write_back_regfile (default parameters, bypass enabled).
module tb_write_back_regfile;

    localparam logic [5:0] OP_ADD  = 6'b110001;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_LDW  = 6'b010111;
    localparam logic [5:0] OP_CALL = 6'b000000;
    localparam logic [5:0] OP_STW  = 6'b010101;
    localparam logic [5:0] OP_NOPE = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        stall = 1'b0;
    logic [5:0]  opcode = OP_NOPE;
    logic [5:0]  src = 6'd0;
    logic [5:0]  dest = 6'd0;
    logic [5:0]  targ = 6'd0;
    logic [31:0] out1 = 32'd0;
    logic [31:0] out2 = 32'd0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] retire_cnt;
    logic [31:0] r [32];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    write_back_regfile dut (
        .clk_40(clk), .rst_n_40(rst_n), .valid_in_40(valid_in), .stall_40(stall),
        .opcode_in_40(opcode), .src_reg_in_40(src), .dest_reg_in_40(dest),
        .targ_reg_in_40(targ), .mem_out1_40(out1), .mem_out2_40(out2),
        .wb_en_40(wb_en), .wb_addr_40(wb_addr), .wb_data_40(wb_data),
        .retire_cnt_40(retire_cnt),
        .r0(r[0]),   .r1(r[1]),   .r2(r[2]),   .r3(r[3]),   .r4(r[4]),   .r5(r[5]),
        .r6(r[6]),   .r7(r[7]),   .r8(r[8]),   .r9(r[9]),   .r10(r[10]), .r11(r[11]),
        .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]), .r16(r[16]), .r17(r[17]),
        .r18(r[18]), .r19(r[19]), .r20(r[20]), .r21(r[21]), .r22(r[22]), .r23(r[23]),
        .r24(r[24]), .r25(r[25]), .r26(r[26]), .r27(r[27]), .r28(r[28]), .r29(r[29]),
        .r30(r[30]), .r31(r[31])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a bundle, clock it in, and settle just after the edge
    task automatic step(input logic v, input logic s, input logic [5:0] op,
                        input logic [5:0] d, input logic [5:0] t, input logic [31:0] data);
        valid_in = v;
        stall    = s;
        opcode   = op;
        dest     = d;
        targ     = t;
        out1     = data;
        out2     = ~data;
        src      = d ^ t;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, OP_NOPE, 6'd0, 6'd0, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("reset_r%0d", i), r[i], (i == 27) ? 32'h0000_1000 : 32'd0);
        end
        chk("reset_cnt", retire_cnt, 32'd0);
        chk("reset_wb_en", 32'(wb_en), 32'd0);

        // ADD r5 <- DEADBEEF: visible via bypass after edge 1, committed after edge 2
        step(1'b1, 1'b0, OP_ADD, 6'd5, 6'd0, 32'hDEAD_BEEF);
        chk("add_wb_en", 32'(wb_en), 32'd1);
        chk("add_wb_addr", 32'(wb_addr), 32'd5);
        chk("add_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("add_r5_bypass", r[5], 32'hDEAD_BEEF);
        chk("add_cnt_before", retire_cnt, 32'd0);
        idle();
        chk("add_wb_en_off", 32'(wb_en), 32'd0);
        chk("add_wb_data_off", wb_data, 32'd0);
        chk("add_r5_commit", r[5], 32'hDEAD_BEEF);
        chk("add_cnt", retire_cnt, 32'd1);

        // Back-to-back LDW/ADDI to r3, then ADD to r0
        step(1'b1, 1'b0, OP_LDW, 6'd0, 6'd3, 32'h12);
        chk("ldw_r3", r[3], 32'h12);
        step(1'b1, 1'b0, OP_ADDI, 6'd0, 6'd3, 32'h34);
        chk("addi_r3", r[3], 32'h34);
        chk("addi_cnt", retire_cnt, 32'd2);
        step(1'b1, 1'b0, OP_ADD, 6'd0, 6'd0, 32'hFF);
        chk("add_r0_wb_en", 32'(wb_en), 32'd0);
        chk("add_r0_r3", r[3], 32'h34);
        idle();
        chk("add_r0_r0", r[0], 32'd0);
        chk("add_r0_cnt", retire_cnt, 32'd4);

        // STW, NOPE, CALL: only CALL writes; retire advances by 2
        step(1'b1, 1'b0, OP_STW, 6'd4, 6'd4, 32'h55);
        chk("stw_wb_en", 32'(wb_en), 32'd0);
        step(1'b1, 1'b0, OP_NOPE, 6'd4, 6'd4, 32'h66);
        chk("nope_wb_en", 32'(wb_en), 32'd0);
        chk("stw_cnt", retire_cnt, 32'd5);
        step(1'b1, 1'b0, OP_CALL, 6'd0, 6'd0, 32'h400);
        chk("call_wb_addr", 32'(wb_addr), 32'd31);
        chk("nope_cnt", retire_cnt, 32'd5);
        idle();
        chk("call_r31", r[31], 32'h400);
        chk("call_r4", r[4], 32'd0);
        chk("call_cnt", retire_cnt, 32'd6);

        // rB index with bit 5 set is suppressed but still retires
        step(1'b1, 1'b0, OP_ADDI, 6'd0, 6'b100011, 32'hAA);
        chk("idx5_wb_en", 32'(wb_en), 32'd0);
        chk("idx5_r3", r[3], 32'h34);

        // Stall three cycles with ADD r7 held upstream, then release
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, OP_ADD, 6'd7, 6'd0, 32'h77);
            chk($sformatf("stall%0d_wb_en", i), 32'(wb_en), 32'd0);
            chk($sformatf("stall%0d_cnt", i), retire_cnt, 32'd7);
        end
        step(1'b1, 1'b0, OP_ADD, 6'd7, 6'd0, 32'h77);
        chk("release_wb_addr", 32'(wb_addr), 32'd7);
        idle();
        chk("release_r7", r[7], 32'h77);
        chk("release_cnt", retire_cnt, 32'd8);
        idle();
        chk("release_cnt_hold", retire_cnt, 32'd8);

        // Async reset while a write to r9 is pending
        step(1'b1, 1'b0, OP_ADD, 6'd9, 6'd0, 32'h99);
        chk("pre_rst_wb_en", 32'(wb_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_r9", r[9], 32'd0);
        chk("rst_r7", r[7], 32'd0);
        chk("rst_r27", r[27], 32'h0000_1000);
        chk("rst_cnt", retire_cnt, 32'd0);
        valid_in = 1'b0;
        opcode   = OP_NOPE;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        chk("post_rst_r9", r[9], 32'd0);
        chk("post_rst_cnt", retire_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
